restriction_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively drives a combinational function-under-test (FUT), such as a 7-input single-output restriction benchmark, over every assignment of its free inputs.
- Inputs selected by a restriction mask are held at fixed values; only the remaining free inputs are swept.
- FUT outputs are packed into truth-table words and streamed out over a valid/ready interface.
- Sits between the benchmark netlist and the truth-table capture / autosymmetry check logic.

---
 rtl/restriction_sweep_pkg.sv | 28 ++
 rtl/restriction_sweep_ctrl_if.sv | 12 +
 rtl/restriction_sweep_pack.sv | 48 ++++
 rtl/restriction_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_restriction_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/restriction_sweep_pkg.sv
// Shared types and helpers for the restriction sweep controller.
package restriction_sweep_pkg;

  localparam int N_MAX = 16;
  localparam int W_DEF = 16;

  typedef logic [N_MAX-1:0] asg_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    EMIT,
    DONE
  } state_e;

  // Bit-index width of a truth-table word; never below one bit.
  function automatic int word_idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int unsigned popcount(input asg_t v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N_MAX; i++) c += {31'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/restriction_sweep_ctrl_if.sv
// Truth-table word stream between the sweep controller and its consumer.
interface restriction_sweep_ctrl_if #(
  parameter int W = 16
) ();
  logic [W-1:0] tt_data;
  logic         tt_valid;
  logic         tt_ready;
  logic         tt_last;

  modport master (output tt_data, output tt_valid, output tt_last, input tt_ready);
  modport slave  (input tt_data, input tt_valid, input tt_last, output tt_ready);
endinterface

// File: rtl/restriction_sweep_pack.sv
// W-bit pack buffer: bit k of a word holds the k-th sampled FUT output.
module restriction_sweep_pack
  import restriction_sweep_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         flush,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int IW = word_idx_w(W);

  logic [W-1:0]  buf_q;
  logic [IW-1:0] fill;

  // word already contains the incoming bit so the caller can load it on the same edge
  always_comb begin
    word       = buf_q;
    word[fill] = bit_in;
  end

  assign full = (fill == IW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      fill  <= '0;
    end else if (clr) begin
      buf_q <= '0;
      fill  <= '0;
    end else if (shift_en) begin
      if (full || flush) begin
        buf_q <= '0;
        fill  <= '0;
      end else begin
        buf_q <= word;
        fill  <= fill + IW'(1);
      end
    end
  end

endmodule

// File: rtl/restriction_sweep_ctrl.sv
// Exhaustive sweep of a FUT over its unmasked inputs, packing outputs into truth-table words.
// Optional onset counter output enabled by RESTRICTION_SWEEP_ONSET_EN.
//
//   state | meaning
//   IDLE  | waiting for start; config latched on acceptance
//   SWEEP | one assignment sampled per cycle into the pack buffer
//   EMIT  | word presented on tt, sweep frozen until accepted
//   DONE  | done pulse visible, busy drops on exit
module restriction_sweep_ctrl
  import restriction_sweep_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] cfg_fix_mask,
  input  logic [N-1:0] cfg_fix_val,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] fut_x,
  input  logic         fut_y,
  restriction_sweep_ctrl_if.master tt
`ifdef RESTRICTION_SWEEP_ONSET_EN
  ,
  output logic [N:0]   onset_cnt
`endif
);

  localparam logic [N-1:0] ALL_ONES = '1;

  state_e       state;
  logic [N-1:0] mask_q;
  logic [N-1:0] val_q;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_or_mask;
  logic [N-1:0] cnt_nxt;
  logic         last_asg;
  logic         start_acc;
  logic         shift_en;
  logic [W-1:0] pk_word;
  logic         pk_full;

  // Forcing masked bits to one lets the carry skip over them.
  assign cnt_or_mask = cnt | mask_q;
  assign cnt_nxt     = (cnt_or_mask + N'(1)) & ~mask_q;
  assign last_asg    = (cnt_or_mask == ALL_ONES);
  assign start_acc   = (state == IDLE) && start;
  assign shift_en    = (state == SWEEP);

  restriction_sweep_pack #(.W(W)) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .shift_en (shift_en),
    .flush    (last_asg),
    .bit_in   (fut_y),
    .word     (pk_word),
    .full     (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fut_x       <= '0;
      cnt         <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      tt.tt_data  <= '0;
      tt.tt_valid <= 1'b0;
      tt.tt_last  <= 1'b0;
`ifdef RESTRICTION_SWEEP_ONSET_EN
      onset_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= cfg_fix_mask;
            val_q  <= cfg_fix_val;
            cnt    <= '0;
            fut_x  <= cfg_fix_val & cfg_fix_mask;
            busy   <= 1'b1;
            state  <= SWEEP;
`ifdef RESTRICTION_SWEEP_ONSET_EN
            onset_cnt <= '0;
`endif
          end
        end
        SWEEP: begin
`ifdef RESTRICTION_SWEEP_ONSET_EN
          onset_cnt <= onset_cnt + (N+1)'(fut_y);
`endif
          // the final assignment stays on fut_x; the counter never wraps
          if (!last_asg) begin
            cnt   <= cnt_nxt;
            fut_x <= cnt_nxt | (val_q & mask_q);
          end
          if (pk_full || last_asg) begin
            tt.tt_data  <= pk_word;
            tt.tt_valid <= 1'b1;
            tt.tt_last  <= last_asg;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (tt.tt_ready) begin
            tt.tt_valid <= 1'b0;
            tt.tt_last  <= 1'b0;
            if (tt.tt_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SWEEP;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restriction_sweep_ctrl.sv
// Scoreboard bench for restriction_sweep_ctrl (N=7, W=16) against a truth-table reference model.
module tb_restriction_sweep_ctrl;

  localparam int N = 7;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] cfg_fix_mask;
  logic [N-1:0] cfg_fix_val;
  logic         busy;
  logic         done;
  logic [N-1:0] fut_x;
  logic         fut_y;
  logic [127:0] fut_tt;
`ifdef RESTRICTION_SWEEP_ONSET_EN
  logic [N:0]   onset_cnt;
  int           exp_onset;
`endif

  restriction_sweep_ctrl_if #(.W(W)) tt_if ();

  always #5 clk = ~clk;

  assign fut_y = fut_tt[fut_x];

  restriction_sweep_ctrl #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_fix_mask (cfg_fix_mask),
    .cfg_fix_val  (cfg_fix_val),
    .busy         (busy),
    .done         (done),
    .fut_x        (fut_x),
    .fut_y        (fut_y),
    .tt           (tt_if)
`ifdef RESTRICTION_SWEEP_ONSET_EN
    ,
    .onset_cnt    (onset_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  logic [N-1:0] exp_x[$];
  logic [W:0]   exp_w[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got nothing, expected an event", name);
  endtask

  // Reference: enumerate every 7-bit input in ascending order, keep those matching the fixed bits.
  task automatic build_model(input logic [N-1:0] m, input logic [N-1:0] v);
    logic [N-1:0] asg[$];
    logic [W-1:0] w;
    int           ones;
    logic [N-1:0] a;
    exp_x.delete();
    exp_w.delete();
    for (int i = 0; i < 128; i++) begin
      a = 7'(i);
      if ((a & m) == (v & m)) asg.push_back(a);
    end
    w    = '0;
    ones = 0;
    for (int j = 0; j < asg.size(); j++) begin
      exp_x.push_back(asg[j]);
      w[j % W] = fut_tt[asg[j]];
      if (fut_tt[asg[j]]) ones++;
      if ((j % W) == W - 1 || j == asg.size() - 1) begin
        exp_w.push_back({(j == asg.size() - 1), w});
        w = '0;
      end
    end
`ifdef RESTRICTION_SWEEP_ONSET_EN
    exp_onset = ones;
`endif
  endtask

  // Monitor
  logic         prev_hs_last = 1'b0;
  logic         prev_stall   = 1'b0;
  logic [W-1:0] prev_data    = '0;
  logic [N-1:0] prev_x       = '0;
  logic         x_seen       = 1'b0;
  logic [N-1:0] last_x       = '0;

  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      prev_hs_last = 1'b0;
      prev_stall   = 1'b0;
      x_seen       = 1'b0;
    end else begin
      check("done_after_last_hs", done, prev_hs_last);
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", tt_if.tt_valid, 1'b1);
        check("stall_data", tt_if.tt_data, prev_data);
        check("stall_fut_x", fut_x, prev_x);
      end
      if (busy) begin
        if (!x_seen || fut_x != last_x) begin
          if (exp_x.size() == 0) note_fail("fut_x_unexpected");
          else check("fut_x_seq", fut_x, exp_x.pop_front());
          last_x = fut_x;
          x_seen = 1'b1;
        end
      end else begin
        x_seen = 1'b0;
      end
      if (tt_if.tt_valid && tt_if.tt_ready) begin
        if (exp_w.size() == 0) begin
          note_fail("word_unexpected");
        end else begin
          e = exp_w.pop_front();
          check("tt_data", tt_if.tt_data, e[W-1:0]);
          check("tt_last", tt_if.tt_last, e[W]);
        end
        hs_cnt++;
      end
      prev_hs_last = tt_if.tt_valid && tt_if.tt_ready && tt_if.tt_last;
      prev_stall   = tt_if.tt_valid && !tt_if.tt_ready;
      prev_data    = tt_if.tt_data;
      prev_x       = fut_x;
    end
  end

  // mode 0: ready always; 1: random ready; 2: ready low 5 cycles on word 2
  task automatic run_sweep(input logic [N-1:0] m, input logic [N-1:0] v, input int mode,
                           input int rst_word);
    int hs0;
    int hold;
    int d0;
    bit got_done;
    build_model(m, v);
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);
    d0 = done_cnt;
    cfg_fix_mask = m;
    cfg_fix_val  = v;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
    hs0      = hs_cnt;
    hold     = 0;
    got_done = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (rst_word >= 0 && tt_if.tt_valid && (hs_cnt - hs0) == rst_word) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", tt_if.tt_valid, 1'b0);
        check("rst_last", tt_if.tt_last, 1'b0);
        check("rst_data", tt_if.tt_data, '0);
        check("rst_fut_x", fut_x, '0);
        exp_x.delete();
        exp_w.delete();
        repeat (3) begin
          @(posedge clk); #1;
          check("rst_hold_done", done, 1'b0);
          check("rst_hold_busy", busy, 1'b0);
        end
        rst_n = 1'b1;
        check("rst_no_done_pulse", done_cnt, d0);
        return;
      end
      case (mode)
        0: tt_if.tt_ready = 1'b1;
        1: tt_if.tt_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tt_if.tt_valid && (hs_cnt - hs0) == 1 && hold < 5) begin
            tt_if.tt_ready = 1'b0;
            hold++;
          end else begin
            tt_if.tt_ready = 1'b1;
          end
        end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        start        = 1'b1;
        cfg_fix_mask = 7'($urandom);
        cfg_fix_val  = 7'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!got_done) begin
      start = 1'b0;
      note_fail("done_timeout");
      return;
    end
`ifdef RESTRICTION_SWEEP_ONSET_EN
    check("onset_cnt", onset_cnt, exp_onset);
`endif
    // start coinciding with done must be ignored
    start        = 1'b1;
    cfg_fix_mask = 7'($urandom);
    cfg_fix_val  = 7'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_at_done_busy", busy, 1'b0);
    check("start_at_done_valid", tt_if.tt_valid, 1'b0);
    @(posedge clk); #1;
    check("idle_after_done", busy, 1'b0);
    check("one_done_pulse", done_cnt, d0 + 1);
    check("words_left", exp_w.size(), 0);
    check("assignments_left", exp_x.size(), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    cfg_fix_mask   = '0;
    cfg_fix_val    = '0;
    tt_if.tt_ready = 1'b0;
    for (int i = 0; i < 128; i++) fut_tt[i] = ((i & 3) == 3);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", tt_if.tt_valid, 1'b0);
    check("reset_last", tt_if.tt_last, 1'b0);
    check("reset_data", tt_if.tt_data, '0);
    check("reset_fut_x", fut_x, '0);
    rst_n = 1'b1;

    run_sweep(7'h00, 7'h00, 0, -1);
    run_sweep(7'h7C, 7'h00, 0, -1);
    run_sweep(7'h7F, 7'h03, 0, -1);
    run_sweep(7'h00, 7'h00, 2, -1);
    run_sweep(7'h00, 7'h00, 0, 2);
    run_sweep(7'h00, 7'h00, 0, -1);

    for (int t = 0; t < 8; t++) begin
      fut_tt = {$urandom, $urandom, $urandom, $urandom};
      run_sweep(7'($urandom) | 7'($urandom), 7'($urandom), 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
